// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Used by both the arbiter and its round-robin grant block.
package mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (CPU vs debug loader).
// On a tie, the requester that was not granted last wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_en,
  input  logic    i_req_cpu,
  input  logic    i_req_dbg,
  output logic    o_gnt_cpu,
  output logic    o_gnt_dbg,
  output req_id_e o_winner
);

  // r_prio_dbg = 1 means the debug port wins the next tie.
  logic r_prio_dbg;
  logic w_pick_dbg;

  assign w_pick_dbg = i_req_dbg && (!i_req_cpu || r_prio_dbg);
  assign o_gnt_cpu  = i_en && i_req_cpu && !w_pick_dbg;
  assign o_gnt_dbg  = i_en && w_pick_dbg;
  assign o_winner   = w_pick_dbg ? REQ_DBG : REQ_CPU;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_dbg <= 1'b0;
    end else if (o_gnt_cpu) begin
      r_prio_dbg <= 1'b1;
    end else if (o_gnt_dbg) begin
      r_prio_dbg <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU memory stage and the debug loader onto one DMEM port.
// One transaction in flight; completion and a new issue can share a cycle.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int MEM_BYTES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  input  logic [BE_W-1:0] cpu_be,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [XLEN-1:0] cpu_rdata,
  output logic            cpu_err,
  output logic            cpu_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  input  logic [BE_W-1:0] dbg_be,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            dbg_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [XLEN-1:0] LP_LIMIT    = XLEN'(MEM_BYTES);
  localparam logic [1:0]      LP_CNT_INIT = 2'(MEM_LAT - 1);

  state_e          r_state;
  logic [1:0]      r_cnt;
  req_id_e         r_owner;
  logic            r_oor;

  logic            w_complete;
  logic            w_can_issue;
  logic            w_issue;
  logic            w_gnt_cpu;
  logic            w_gnt_dbg;
  req_id_e         w_winner;
  logic            w_win_we;
  logic [XLEN-1:0] w_win_addr;
  logic [XLEN-1:0] w_win_wdata;
  logic [BE_W-1:0] w_win_be;
  logic            w_oor;
  logic            w_mem_en;
  logic            w_cpu_busy;

  assign w_complete  = !rst && (r_state == ST_WAIT) && (r_cnt == 2'd0);
  assign w_can_issue = !rst && ((r_state == ST_IDLE) || (r_cnt == 2'd0));

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_can_issue),
    .i_req_cpu (cpu_req),
    .i_req_dbg (dbg_req),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_dbg (w_gnt_dbg),
    .o_winner  (w_winner)
  );

  assign w_issue = w_gnt_cpu || w_gnt_dbg;

  always_comb begin
    w_win_we    = cpu_we;
    w_win_addr  = cpu_addr;
    w_win_wdata = cpu_wdata;
    w_win_be    = cpu_be;
    if (w_winner == REQ_DBG) begin
      w_win_we    = dbg_we;
      w_win_addr  = dbg_addr;
      w_win_wdata = dbg_wdata;
      w_win_be    = dbg_be;
    end
  end

  // Out-of-range accesses are granted but never reach the memory.
  assign w_oor    = (w_win_addr >= LP_LIMIT);
  assign w_mem_en = w_issue && !w_oor;

  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_en ? w_win_we    : 1'b0;
  assign mem_be    = w_mem_en ? w_win_be    : '0;
  assign mem_addr  = w_mem_en ? w_win_addr  : '0;
  assign mem_wdata = w_mem_en ? w_win_wdata : '0;

  assign cpu_gnt    = w_gnt_cpu;
  assign dbg_gnt    = w_gnt_dbg;
  assign cpu_rvalid = w_complete && (r_owner == REQ_CPU);
  assign dbg_rvalid = w_complete && (r_owner == REQ_DBG);
  assign cpu_err    = cpu_rvalid && r_oor;
  assign dbg_err    = dbg_rvalid && r_oor;
  assign cpu_rdata  = (cpu_rvalid && !r_oor) ? mem_rdata : '0;
  assign dbg_rdata  = (dbg_rvalid && !r_oor) ? mem_rdata : '0;

  // A CPU access counts as in flight from its grant cycle up to (not including) its rvalid cycle.
  assign w_cpu_busy = !rst && (r_state == ST_WAIT) && (r_owner == REQ_CPU);
  assign cpu_stall  = !rst && ((cpu_req && !w_gnt_cpu) ||
                               ((w_gnt_cpu || w_cpu_busy) && !cpu_rvalid));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_owner <= REQ_CPU;
      r_oor   <= 1'b0;
    end else if (w_issue) begin
      r_state <= ST_WAIT;
      r_cnt   <= LP_CNT_INIT;
      r_owner <= w_winner;
      r_oor   <= w_oor;
    end else if (w_complete) begin
      r_state <= ST_IDLE;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (MEM_LAT 1..4) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int MB = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req   [1:4];
  logic        cpu_we    [1:4];
  logic [31:0] cpu_addr  [1:4];
  logic [31:0] cpu_wdata [1:4];
  logic [3:0]  cpu_be    [1:4];
  logic        dbg_req   [1:4];
  logic        dbg_we    [1:4];
  logic [31:0] dbg_addr  [1:4];
  logic [31:0] dbg_wdata [1:4];
  logic [3:0]  dbg_be    [1:4];
  logic        cpu_gnt   [1:4];
  logic        cpu_rvalid[1:4];
  logic [31:0] cpu_rdata [1:4];
  logic        cpu_err   [1:4];
  logic        cpu_stall [1:4];
  logic        dbg_gnt   [1:4];
  logic        dbg_rvalid[1:4];
  logic [31:0] dbg_rdata [1:4];
  logic        dbg_err   [1:4];
  logic        mem_en    [1:4];
  logic        mem_we    [1:4];
  logic [3:0]  mem_be    [1:4];
  logic [31:0] mem_addr  [1:4];
  logic [31:0] mem_wdata [1:4];
  logic [31:0] mem_rdata [1:4];

  for (genvar gi = 1; gi <= 4; gi++) begin : g_dut
    dmem_arbiter #(.MEM_LAT(gi), .MEM_BYTES(MB)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req[gi]), .cpu_we(cpu_we[gi]), .cpu_addr(cpu_addr[gi]),
      .cpu_wdata(cpu_wdata[gi]), .cpu_be(cpu_be[gi]),
      .cpu_gnt(cpu_gnt[gi]), .cpu_rvalid(cpu_rvalid[gi]), .cpu_rdata(cpu_rdata[gi]),
      .cpu_err(cpu_err[gi]), .cpu_stall(cpu_stall[gi]),
      .dbg_req(dbg_req[gi]), .dbg_we(dbg_we[gi]), .dbg_addr(dbg_addr[gi]),
      .dbg_wdata(dbg_wdata[gi]), .dbg_be(dbg_be[gi]),
      .dbg_gnt(dbg_gnt[gi]), .dbg_rvalid(dbg_rvalid[gi]), .dbg_rdata(dbg_rdata[gi]),
      .dbg_err(dbg_err[gi]),
      .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_be(mem_be[gi]),
      .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit fix_rdata = 1'b0;

  // Transaction-level model: one in-flight record per instance, due at an absolute cycle.
  bit m_busy    [1:4];
  bit m_own_dbg [1:4];
  bit m_err     [1:4];
  int m_due     [1:4];
  bit m_last_dbg[1:4];
  bit e_cg      [1:4];
  bit e_dg      [1:4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int l = 1; l <= 4; l++) begin
      bit compl, issue, wdbg, oor, w_we, e_men, e_cv, e_dv, e_st, busy_cpu;
      logic [31:0] w_addr, w_wdata, e_cr, e_dr;
      logic [3:0]  w_be;
      compl = !rst && m_busy[l] && (cyc == m_due[l]);
      wdbg  = (cpu_req[l] && dbg_req[l]) ? !m_last_dbg[l] : dbg_req[l];
      issue = !rst && (!m_busy[l] || compl) && (cpu_req[l] || dbg_req[l]);
      w_we    = wdbg ? dbg_we[l]    : cpu_we[l];
      w_addr  = wdbg ? dbg_addr[l]  : cpu_addr[l];
      w_wdata = wdbg ? dbg_wdata[l] : cpu_wdata[l];
      w_be    = wdbg ? dbg_be[l]    : cpu_be[l];
      oor     = (w_addr >= MB);
      e_cg[l] = issue && !wdbg;
      e_dg[l] = issue && wdbg;
      e_men   = issue && !oor;
      e_cv    = compl && !m_own_dbg[l];
      e_dv    = compl && m_own_dbg[l];
      e_cr    = (e_cv && !m_err[l]) ? mem_rdata[l] : 32'h0;
      e_dr    = (e_dv && !m_err[l]) ? mem_rdata[l] : 32'h0;
      busy_cpu = !rst && m_busy[l] && !m_own_dbg[l];
      e_st    = !rst && ((cpu_req[l] && !e_cg[l]) || ((e_cg[l] || busy_cpu) && !e_cv));

      chk($sformatf("L%0d cpu_gnt", l),    32'(cpu_gnt[l]),    32'(e_cg[l]));
      chk($sformatf("L%0d dbg_gnt", l),    32'(dbg_gnt[l]),    32'(e_dg[l]));
      chk($sformatf("L%0d mem_en", l),     32'(mem_en[l]),     32'(e_men));
      chk($sformatf("L%0d mem_we", l),     32'(mem_we[l]),     e_men ? 32'(w_we) : 32'h0);
      chk($sformatf("L%0d mem_be", l),     32'(mem_be[l]),     e_men ? 32'(w_be) : 32'h0);
      chk($sformatf("L%0d mem_addr", l),   mem_addr[l],        e_men ? w_addr : 32'h0);
      chk($sformatf("L%0d mem_wdata", l),  mem_wdata[l],       e_men ? w_wdata : 32'h0);
      chk($sformatf("L%0d cpu_rvalid", l), 32'(cpu_rvalid[l]), 32'(e_cv));
      chk($sformatf("L%0d dbg_rvalid", l), 32'(dbg_rvalid[l]), 32'(e_dv));
      chk($sformatf("L%0d cpu_rdata", l),  cpu_rdata[l],       e_cr);
      chk($sformatf("L%0d dbg_rdata", l),  dbg_rdata[l],       e_dr);
      chk($sformatf("L%0d cpu_err", l),    32'(cpu_err[l]),    32'(e_cv && m_err[l]));
      chk($sformatf("L%0d dbg_err", l),    32'(dbg_err[l]),    32'(e_dv && m_err[l]));
      chk($sformatf("L%0d cpu_stall", l),  32'(cpu_stall[l]),  32'(e_st));

      if (compl)
        $display("[TB] L%0d cyc %0d done owner=%s err=%0d", l, cyc,
                 m_own_dbg[l] ? "dbg" : "cpu", m_err[l]);

      if (rst) begin
        m_busy[l]     = 1'b0;
        m_last_dbg[l] = 1'b1;
      end else if (issue) begin
        m_busy[l]     = 1'b1;
        m_own_dbg[l]  = wdbg;
        m_err[l]      = oor;
        m_due[l]      = cyc + l;
        m_last_dbg[l] = wdbg;
      end else if (compl) begin
        m_busy[l] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    for (int l = 1; l <= 4; l++) mem_rdata[l] = fix_rdata ? 32'hDEADBEEF : $urandom;
  endtask

  task automatic cycle_end();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'(MB);
      1:       return 32'(MB - 1);
      2:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, MB - 1));
    endcase
  endfunction

  task automatic rand_req(input int l);
    if (!cpu_req[l] || e_cg[l]) begin
      cpu_req[l]   = ($urandom_range(0, 3) != 0);
      cpu_we[l]    = 1'($urandom_range(0, 1));
      cpu_addr[l]  = rand_addr();
      cpu_wdata[l] = $urandom;
      cpu_be[l]    = 4'($urandom);
    end
    if (!dbg_req[l] || e_dg[l]) begin
      dbg_req[l]   = ($urandom_range(0, 2) == 0);
      dbg_we[l]    = 1'($urandom_range(0, 1));
      dbg_addr[l]  = rand_addr();
      dbg_wdata[l] = $urandom;
      dbg_be[l]    = 4'($urandom);
    end
  endtask

  // Idle cycles on instance l: any granted request is withdrawn.
  task automatic drain(input int l, input int n);
    for (int k = 0; k < n; k++) begin
      cycle_begin();
      if (e_cg[l]) cpu_req[l] = 1'b0;
      if (e_dg[l]) dbg_req[l] = 1'b0;
      cycle_end();
    end
  endtask

  int g_who[$];
  int g_cyc[$];
  int v_cyc[$];

  initial begin
    rst = 1'b1;
    for (int l = 1; l <= 4; l++) begin
      cpu_req[l] = 0; cpu_we[l] = 0; cpu_addr[l] = 0; cpu_wdata[l] = 0; cpu_be[l] = 0;
      dbg_req[l] = 0; dbg_we[l] = 0; dbg_addr[l] = 0; dbg_wdata[l] = 0; dbg_be[l] = 0;
      mem_rdata[l] = 0; m_last_dbg[l] = 1'b1;
    end

    // Reset with a pending CPU request: all outputs must stay low.
    cycle_begin(); cycle_end();
    cycle_begin(); cpu_req[1] = 1'b1; cpu_addr[1] = 32'h10; cycle_end();
    chk("rst cpu_gnt", 32'(cpu_gnt[1]), 32'h0);
    chk("rst cpu_stall", 32'(cpu_stall[1]), 32'h0);
    cpu_req[1] = 1'b0;

    // Single load, MEM_LAT=1.
    cycle_begin(); rst = 1'b0; fix_rdata = 1'b1; cycle_end();
    cycle_begin();
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h10; cpu_be[1] = 4'hF;
    cycle_end();
    chk("ld gnt T", 32'(cpu_gnt[1]), 32'h1);
    chk("ld stall T", 32'(cpu_stall[1]), 32'h1);
    chk("ld mem_addr T", mem_addr[1], 32'h10);
    cycle_begin(); cpu_req[1] = 1'b0; cycle_end();
    chk("ld rvalid T+1", 32'(cpu_rvalid[1]), 32'h1);
    chk("ld rdata T+1", cpu_rdata[1], 32'hDEADBEEF);
    chk("ld stall T+1", 32'(cpu_stall[1]), 32'h0);
    fix_rdata = 1'b0;
    drain(1, 2);

    // Four back-to-back stores, MEM_LAT=1.
    for (int k = 0; k < 4; k++) begin
      cycle_begin();
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b1; cpu_addr[1] = 32'(4 * k); cpu_wdata[1] = $urandom;
      cycle_end();
      chk($sformatf("st%0d mem_en", k), 32'(mem_en[1]), 32'h1);
      chk($sformatf("st%0d rvalid", k), 32'(cpu_rvalid[1]), (k > 0) ? 32'h1 : 32'h0);
    end
    cycle_begin(); cpu_req[1] = 1'b0; cycle_end();
    chk("st last rvalid", 32'(cpu_rvalid[1]), 32'h1);
    chk("st idle mem_en", 32'(mem_en[1]), 32'h0);
    drain(1, 2);

    // Contending requesters, MEM_LAT=3: grants alternate.
    cpu_addr[3] = 32'h100; dbg_addr[3] = 32'h200;
    for (int k = 0; k < 12; k++) begin
      cycle_begin();
      if (!cpu_req[3] || e_cg[3]) begin cpu_req[3] = 1'b1; cpu_addr[3] = cpu_addr[3] + 4; end
      if (!dbg_req[3] || e_dg[3]) begin dbg_req[3] = 1'b1; dbg_addr[3] = dbg_addr[3] + 4; end
      cycle_end();
      if (cpu_gnt[3]) begin g_who.push_back(0); g_cyc.push_back(cyc); end
      if (dbg_gnt[3]) begin g_who.push_back(1); g_cyc.push_back(cyc); end
      if (cpu_rvalid[3] || dbg_rvalid[3]) v_cyc.push_back(cyc);
    end
    chk("rr grant count>=3", 32'(g_who.size() >= 3), 32'h1);
    chk("rr rvalid count>=3", 32'(v_cyc.size() >= 3), 32'h1);
    if (g_who.size() >= 3 && v_cyc.size() >= 3) begin
      chk("rr grant0 cpu", 32'(g_who[0]), 32'h0);
      chk("rr grant1 dbg", 32'(g_who[1]), 32'h1);
      chk("rr grant2 cpu", 32'(g_who[2]), 32'h0);
      for (int k = 0; k < 3; k++) chk($sformatf("rr lat%0d", k), 32'(v_cyc[k] - g_cyc[k]), 32'h3);
    end
    drain(3, 8);

    // Out-of-range debug store, MEM_LAT=2.
    cycle_begin();
    dbg_req[2] = 1'b1; dbg_we[2] = 1'b1; dbg_addr[2] = 32'h2000; dbg_wdata[2] = 32'h1234; dbg_be[2] = 4'hF;
    cycle_end();
    chk("oor gnt", 32'(dbg_gnt[2]), 32'h1);
    chk("oor mem_en", 32'(mem_en[2]), 32'h0);
    chk("oor mem_addr", mem_addr[2], 32'h0);
    cycle_begin(); dbg_req[2] = 1'b0; cycle_end();
    chk("oor rvalid early", 32'(dbg_rvalid[2]), 32'h0);
    cycle_begin(); cycle_end();
    chk("oor rvalid", 32'(dbg_rvalid[2]), 32'h1);
    chk("oor err", 32'(dbg_err[2]), 32'h1);
    chk("oor rdata", dbg_rdata[2], 32'h0);
    drain(2, 2);

    // Reset while a MEM_LAT=4 load is in flight.
    cycle_begin(); cpu_req[4] = 1'b1; cpu_we[4] = 1'b0; cpu_addr[4] = 32'h40; cycle_end();
    chk("rst4 gnt", 32'(cpu_gnt[4]), 32'h1);
    cycle_begin(); cpu_req[4] = 1'b0; cycle_end();
    cycle_begin(); rst = 1'b1; cpu_req[4] = 1'b1; dbg_req[4] = 1'b1; dbg_addr[4] = 32'h80; cycle_end();
    chk("rst4 cpu_gnt", 32'(cpu_gnt[4]), 32'h0);
    chk("rst4 dbg_gnt", 32'(dbg_gnt[4]), 32'h0);
    chk("rst4 stall", 32'(cpu_stall[4]), 32'h0);
    cycle_begin(); rst = 1'b0; cycle_end();
    chk("rst4 first cpu_gnt", 32'(cpu_gnt[4]), 32'h1);
    chk("rst4 first dbg_gnt", 32'(dbg_gnt[4]), 32'h0);
    cycle_begin(); cpu_req[4] = 1'b0; cycle_end();
    chk("rst4 old rvalid gone", 32'(cpu_rvalid[4]), 32'h0);
    drain(4, 10);

    // Randomized traffic on every latency, with occasional reset pulses.
    for (int l = 1; l <= 4; l++) begin
      for (int k = 0; k < 300; k++) begin
        cycle_begin();
        rst = ($urandom_range(0, 63) == 0);
        rand_req(l);
        cycle_end();
      end
      rst = 1'b0;
      drain(l, 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
